// File: rtl/radio_frame_rx_if.sv
// Link-side bundle for radio_frame_rx: serial inputs plus the deserialised
// word, lock status and error strobes.
interface radio_frame_rx_if #(
  parameter int unsigned FRAME_BITS = 8,
  parameter int unsigned ERR_W      = 16
);
  logic                  data_in;
  logic                  sync_in;
  logic [FRAME_BITS-1:0] sample_out;
  logic                  sample_valid;
  logic                  locked;
  logic                  sync_err;
  logic                  parity_err;
  logic [ERR_W-1:0]      err_count;

  modport master (
    output data_in, sync_in,
    input  sample_out, sample_valid, locked, sync_err, parity_err, err_count
  );

  modport slave (
    input  data_in, sync_in,
    output sample_out, sample_valid, locked, sync_err, parity_err, err_count
  );
endinterface

// File: rtl/radio_frame_rx.sv
// Radio link deserializer: acquires frame lock from SYNC, rebuilds MSB-first frames.
// Define RADIO_RX_PARITY_EN to append and check an even-parity bit per frame.
module radio_frame_rx #(
  parameter int unsigned FRAME_BITS  = 8,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned ERR_W       = 16
) (
  input logic             data_clk_i,
  input logic             rst_i,
  radio_frame_rx_if.slave link_io
);

`ifdef RADIO_RX_PARITY_EN
  localparam int unsigned FrameLen = FRAME_BITS + 1;
`else
  localparam int unsigned FrameLen = FRAME_BITS;
`endif
  localparam int unsigned IdxW = $clog2(FrameLen);
  localparam int unsigned CntW = $clog2(LOCK_FRAMES + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FrameLen - 1);
  localparam logic [CntW-1:0] LockCnt = CntW'(LOCK_FRAMES);

  typedef enum logic [1:0] {StHunt, StAcquire, StLocked} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CntW-1:0]       good_q, good_d;
  logic                  data_q, sync_q;
  logic [FrameLen-1:0]   shift_q, shift_d;
  logic                  done_q, done_d;
  logic [FRAME_BITS-1:0] sample_q, sample_d;
  logic                  valid_q;
  logic                  sync_err_q, sync_err_d;
  logic                  parity_err_q, parity_err_d;
  logic [ERR_W-1:0]      err_cnt_q, err_cnt_d;

  logic in_frame, at_bound, at_last, miss_sync, early_sync, good_bound, is_locked;
  logic [IdxW-1:0] idx_next;

  // idx_q is the frame index the currently registered bit is expected to carry
  always_comb begin
    in_frame   = (state_q != StHunt);
    at_bound   = (idx_q == '0);
    at_last    = (idx_q == LastIdx);
    miss_sync  = in_frame & at_bound & ~sync_q;
    early_sync = in_frame & ~at_bound & sync_q;
    good_bound = in_frame & at_bound & sync_q;
    idx_next   = at_last ? '0 : idx_q + IdxW'(1);
  end

  always_ff @(posedge data_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StHunt;
      idx_q   <= '0;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      good_q  <= good_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    good_d  = good_q;
    case (state_q)
      StHunt: begin
        if (sync_q) begin
          state_d = StAcquire;
          good_d  = '0;
          idx_d   = IdxW'(1);
        end
      end
      StAcquire, StLocked: begin
        if (miss_sync) begin
          state_d = StHunt;
          idx_d   = '0;
        end else if (early_sync) begin
          // The misplaced SYNC bit itself starts the new frame
          state_d = StAcquire;
          good_d  = '0;
          idx_d   = IdxW'(1);
        end else begin
          idx_d = idx_next;
          if (good_bound && state_q == StAcquire) begin
            if (good_q + CntW'(1) == LockCnt) begin
              state_d = StLocked;
              good_d  = '0;
            end else begin
              good_d = good_q + CntW'(1);
            end
          end
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_comb begin
    is_locked  = (state_q == StLocked);
    sync_err_d = miss_sync | early_sync;
    done_d     = is_locked & at_last & ~early_sync;
    shift_d    = {shift_q[FrameLen-2:0], data_q};
    sample_d   = done_q ? shift_q[FrameLen-1 -: FRAME_BITS] : sample_q;
`ifdef RADIO_RX_PARITY_EN
    parity_err_d = done_q & (^shift_q);
`else
    parity_err_d = 1'b0;
`endif
    err_cnt_d = err_cnt_q;
    if ((sync_err_d | parity_err_d) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge data_clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q       <= 1'b0;
      sync_q       <= 1'b0;
      shift_q      <= '0;
      done_q       <= 1'b0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
      sync_err_q   <= 1'b0;
      parity_err_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      data_q       <= link_io.data_in;
      sync_q       <= link_io.sync_in;
      shift_q      <= shift_d;
      done_q       <= done_d;
      sample_q     <= sample_d;
      valid_q      <= done_q;
      sync_err_q   <= sync_err_d;
      parity_err_q <= parity_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign link_io.sample_out   = sample_q;
  assign link_io.sample_valid = valid_q;
  assign link_io.locked       = is_locked;
  assign link_io.sync_err     = sync_err_q;
  assign link_io.parity_err   = parity_err_q;
  assign link_io.err_count    = err_cnt_q;

endmodule

// File: tb/tb_radio_frame_rx.sv
// Scoreboard bench for radio_frame_rx; a second instance with a 4-bit error
// counter shares the stimulus to exercise saturation.
module tb_radio_frame_rx;

`ifdef RADIO_RX_PARITY_EN
  localparam int L = 9;
`else
  localparam int L = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  radio_frame_rx_if #(.FRAME_BITS(8), .ERR_W(16)) bus ();
  radio_frame_rx_if #(.FRAME_BITS(8), .ERR_W(4))  sbus ();

  assign sbus.data_in = bus.data_in;
  assign sbus.sync_in = bus.sync_in;

  radio_frame_rx #(.FRAME_BITS(8), .LOCK_FRAMES(2), .ERR_W(16)) dut (
    .data_clk_i (clk),
    .rst_i      (rst),
    .link_io    (bus)
  );

  radio_frame_rx #(.FRAME_BITS(8), .LOCK_FRAMES(2), .ERR_W(4)) dut_small (
    .data_clk_i (clk),
    .rst_i      (rst),
    .link_io    (sbus)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int exp_err  = 0;
  int exp_pulses = 0;
  int pulses   = 0;
  logic [8:0] sb_q[$];
  logic [8:0] sb_word;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sync_err) pulses++;
      if (bus.sample_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_valid", 32'(bus.sample_valid), 32'd0);
        end else begin
          sb_word = sb_q.pop_front();
          check_eq("sample_out", 32'(bus.sample_out), 32'(sb_word[7:0]));
          check_eq("parity_err", 32'(bus.parity_err), 32'(sb_word[8]));
        end
      end else if (bus.parity_err) begin
        check_eq("parity_without_valid", 32'(bus.parity_err), 32'd0);
      end
    end
  end

  function automatic logic [L-1:0] mk(input logic [7:0] w, input bit par_ok);
`ifdef RADIO_RX_PARITY_EN
    return {w, (^w) ^ ~par_ok};
`else
    return (par_ok) ? w : w;
`endif
  endfunction

  task automatic send_bit(input logic d, input logic s);
    @(posedge clk);
    #1;
    bus.data_in = d;
    bus.sync_in = s;
  endtask

  task automatic send_bits(input logic [L-1:0] f, input int first, input int cnt,
                           input int sync_idx);
    for (int i = first; i < first + cnt; i++) send_bit(f[L-1-i], i == sync_idx);
  endtask

  task automatic frame(input logic [7:0] w, input bit emit);
    if (emit) sb_q.push_back({1'b0, w});
    send_bits(mk(w, 1'b1), 0, L, 0);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.data_in = 1'b0;
    bus.sync_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
  endtask

  task automatic check_status(input string tag, input logic exp_locked);
    check_eq({tag, "_locked"}, 32'(bus.locked), 32'(exp_locked));
    check_eq({tag, "_err_count"}, 32'(bus.err_count), 32'(exp_err));
    check_eq({tag, "_sync_pulses"}, 32'(pulses), 32'(exp_pulses));
    check_eq({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    bus.data_in = 1'b0;
    bus.sync_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_sample_out", 32'(bus.sample_out), 32'd0);
    check_eq("rst_valid", 32'(bus.sample_valid), 32'd0);
    check_eq("rst_locked", 32'(bus.locked), 32'd0);
    check_eq("rst_sync_err", 32'(bus.sync_err), 32'd0);
    check_eq("rst_err_count", 32'(bus.err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Lock after two good boundaries; only frames from lock on are emitted
    frame(8'hA5, 1'b0);
    frame(8'h3C, 1'b0);
    check_eq("lock_after_f2", 32'(bus.locked), 32'd0);
    frame(8'hFF, 1'b1);
    check_eq("lock_after_f3", 32'(bus.locked), 32'd1);
    frame(8'h01, 1'b1);
    send_bits(mk(8'h02, 1'b1), 0, 3, 0);
    settle();
    check_status("basic", 1'b1);

    // Asynchronous reset mid-frame, away from any clock edge
    rst = 1'b1;
    #1;
    check_eq("async_sample_out", 32'(bus.sample_out), 32'd0);
    check_eq("async_valid", 32'(bus.sample_valid), 32'd0);
    check_eq("async_locked", 32'(bus.locked), 32'd0);
    check_eq("async_err_count", 32'(bus.err_count), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_bits(mk(8'h02, 1'b1), 3, L - 3, L);
    send_bits(mk(8'h00, 1'b1), 0, L, L);
    settle();
    check_status("after_rst", 1'b0);

    // Early SYNC at index 5 of a locked frame
    frame(8'h10, 1'b0);
    frame(8'h20, 1'b0);
    frame(8'h30, 1'b1);
    send_bits(mk(8'h40, 1'b1), 0, 5, 0);
    frame(8'h50, 1'b0);
    exp_err = 1;
    exp_pulses = 1;
    check_status("early", 1'b0);
    frame(8'h60, 1'b0);
    frame(8'h70, 1'b1);
    sb_q.push_back({1'b0, 8'h80});
    send_bits(mk(8'h80, 1'b1), 0, 3, 0);
    settle();
    check_eq("relock_pending", 32'(sb_q.size()), 32'd1);
    check_eq("relock_locked", 32'(bus.locked), 32'd1);

    // Missing SYNC at a locked boundary
    send_bits(mk(8'h80, 1'b1), 3, L - 3, L);
    send_bits(mk(8'h90, 1'b1), 0, L, L);
    settle();
    exp_err = 2;
    exp_pulses = 2;
    check_status("missing", 1'b0);
    frame(8'hA0, 1'b0);
    frame(8'hB0, 1'b0);
    frame(8'hC0, 1'b1);
    send_bits(mk(8'hD0, 1'b1), 0, 3, 0);
    settle();
    check_status("relock2", 1'b1);

    // Missing SYNC on the boundary that would have locked
    do_reset();
    frame(8'h11, 1'b0);
    frame(8'h22, 1'b0);
    send_bits(mk(8'h33, 1'b1), 0, L, L);
    settle();
    exp_err = 1;
    exp_pulses = 3;
    check_status("wouldlock", 1'b0);
    check_eq("small_err_1", 32'(sbus.err_count), 32'd1);

    // Repeated early SYNCs drive the 4-bit counter into saturation
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b1);
    end
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    settle();
    exp_err = 21;
    exp_pulses = 23;
    check_status("sat", 1'b0);
    check_eq("small_sat", 32'(sbus.err_count), 32'hF);
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b1);
    end
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    settle();
    exp_err = 24;
    exp_pulses = 26;
    check_status("sat_hold", 1'b0);
    check_eq("small_sat_hold", 32'(sbus.err_count), 32'hF);

`ifdef RADIO_RX_PARITY_EN
    // Bad parity still presents the word and keeps lock
    do_reset();
    frame(8'h01, 1'b0);
    frame(8'h02, 1'b0);
    frame(8'h03, 1'b1);
    sb_q.push_back({1'b1, 8'h07});
    send_bits(mk(8'h07, 1'b0), 0, L, 0);
    sb_q.push_back({1'b0, 8'h07});
    send_bits(mk(8'h07, 1'b1), 0, L, 0);
    send_bits(mk(8'h00, 1'b1), 0, 3, 0);
    settle();
    exp_err = 1;
    check_status("parity", 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
